// File: rtl/match_ctrl.sv
// Pong match sequencer: serve countdown, live play, post-point pause, game over; owns both scores.
// Optional MATCH_PAUSE_EN adds a pause input / paused output that freezes the match while set.
module match_ctrl #(
   parameter int WIN_SCORE    = 5,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timing_tick,
   input  logic       start,
   input  logic       goal_p1,
   input  logic       goal_p2,
   output logic       ball_en,
   output logic       ball_rst,
   output logic       serve_dir,
   output logic [3:0] player1_score,
   output logic [3:0] player2_score,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
`ifdef MATCH_PAUSE_EN
   ,
   input  logic       pause,
   output logic       paused
`endif
);

   localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CW = $clog2(MAX_FRAMES + 1);
   localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES);
   localparam logic [CW-1:0] POINT_LD = CW'(POINT_FRAMES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   state_t        st;
   logic [CW-1:0] cnt;
   logic          start_q;
   logic          start_edge;
   logic [3:0]    p1_inc;
   logic [3:0]    p2_inc;
   logic          freeze;
   logic          resume;

   assign state      = st;
   assign start_edge = start & ~start_q;
   assign p1_inc     = (player1_score == 4'd15) ? 4'd15 : player1_score + 4'd1;
   assign p2_inc     = (player2_score == 4'd15) ? 4'd15 : player2_score + 4'd1;

`ifdef MATCH_PAUSE_EN
   logic pause_q;
   logic pause_edge;

   assign pause_edge = pause & ~pause_q;
   // A pause edge cycle only toggles paused; nothing else advances in that cycle.
   assign freeze     = pause_edge | paused;
   assign resume     = pause_edge & paused;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pause_q <= 1'b0;
         paused  <= 1'b0;
      end else begin
         pause_q <= pause;
         if (st == IDLE || st == OVER)
            paused <= 1'b0;
         else if (pause_edge)
            paused <= ~paused;
      end
   end
`else
   assign freeze = 1'b0;
   assign resume = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= IDLE;
         cnt           <= '0;
         start_q       <= 1'b0;
         ball_en       <= 1'b0;
         ball_rst      <= 1'b1;
         serve_dir     <= 1'b0;
         player1_score <= 4'd0;
         player2_score <= 4'd0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
      end else begin
         start_q <= start;
         case (st)
            IDLE, OVER: begin
               ball_en  <= 1'b0;
               ball_rst <= 1'b1;
               if (start_edge) begin
                  player1_score <= 4'd0;
                  player2_score <= 4'd0;
                  serve_dir     <= 1'b0;
                  game_over     <= 1'b0;
                  cnt           <= SERVE_LD;
                  st            <= SERVE;
               end
            end

            SERVE: begin
               ball_en  <= 1'b0;
               ball_rst <= 1'b1;
               if (!freeze && timing_tick) begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     st       <= PLAY;
                     ball_en  <= 1'b1;
                     ball_rst <= 1'b0;
                  end
               end
            end

            PLAY: begin
               ball_rst <= 1'b0;
               if (freeze) begin
                  ball_en <= resume;
               end else if (goal_p1) begin
                  // goal_p1 wins a simultaneous goal; ticks in this cycle are not counted
                  player1_score <= p1_inc;
                  serve_dir     <= 1'b1;
                  ball_en       <= 1'b0;
                  if (p1_inc == WIN) begin
                     st        <= OVER;
                     game_over <= 1'b1;
                     winner    <= 1'b0;
                     ball_rst  <= 1'b1;
                  end else begin
                     st  <= POINT;
                     cnt <= POINT_LD;
                  end
               end else if (goal_p2) begin
                  player2_score <= p2_inc;
                  serve_dir     <= 1'b0;
                  ball_en       <= 1'b0;
                  if (p2_inc == WIN) begin
                     st        <= OVER;
                     game_over <= 1'b1;
                     winner    <= 1'b1;
                     ball_rst  <= 1'b1;
                  end else begin
                     st  <= POINT;
                     cnt <= POINT_LD;
                  end
               end else begin
                  ball_en <= 1'b1;
               end
            end

            POINT: begin
               ball_en  <= 1'b0;
               ball_rst <= 1'b0;
               if (!freeze && timing_tick) begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     st       <= SERVE;
                     cnt      <= SERVE_LD;
                     ball_rst <= 1'b1;
                  end
               end
            end

            default: begin
               st       <= IDLE;
               ball_en  <= 1'b0;
               ball_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl (default build) with short frame counts.
module tb_match_ctrl;
   localparam int SF = 3;
   localparam int PF = 5;
   localparam int WS = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       timing_tick;
   logic       start;
   logic       goal_p1;
   logic       goal_p2;
   logic       ball_en;
   logic       ball_rst;
   logic       serve_dir;
   logic [3:0] player1_score;
   logic [3:0] player2_score;
   logic       game_over;
   logic       winner;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   match_ctrl #(.WIN_SCORE(WS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
      .clk(clk), .rst(rst), .timing_tick(timing_tick), .start(start),
      .goal_p1(goal_p1), .goal_p2(goal_p2), .ball_en(ball_en), .ball_rst(ball_rst),
      .serve_dir(serve_dir), .player1_score(player1_score), .player2_score(player2_score),
      .game_over(game_over), .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         timing_tick = 1'b1;
         step();
         timing_tick = 1'b0;
         step();
      end
   endtask

   task automatic goal(input logic a, input logic b, input logic t);
      goal_p1 = a;
      goal_p2 = b;
      timing_tick = t;
      step();
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
      timing_tick = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; timing_tick = 1'b0; start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
      step(); step();
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_ball_en", 8'(ball_en), 8'd0);
      chk("rst_ball_rst", 8'(ball_rst), 8'd1);
      chk("rst_serve_dir", 8'(serve_dir), 8'd0);
      chk("rst_p1", 8'(player1_score), 8'd0);
      chk("rst_p2", 8'(player2_score), 8'd0);
      chk("rst_game_over", 8'(game_over), 8'd0);
      chk("rst_winner", 8'(winner), 8'd0);
      rst = 1'b0;
      step();

      // IDLE -> SERVE -> PLAY after exactly SF ticks
      start_pulse();
      chk("serve_state", 8'(state), 8'd1);
      chk("serve_ball_rst", 8'(ball_rst), 8'd1);
      ticks(SF - 1);
      chk("serve_not_done", 8'(state), 8'd1);
      ticks(1);
      chk("play_state", 8'(state), 8'd2);
      chk("play_ball_en", 8'(ball_en), 8'd1);
      chk("play_ball_rst", 8'(ball_rst), 8'd0);
      start_pulse();
      chk("play_start_ignored", 8'(state), 8'd2);

      // player 1 point
      goal(1'b1, 1'b0, 1'b0);
      chk("g1_p1", 8'(player1_score), 8'd1);
      chk("g1_serve_dir", 8'(serve_dir), 8'd1);
      chk("g1_state", 8'(state), 8'd3);
      chk("g1_ball_en", 8'(ball_en), 8'd0);
      chk("g1_ball_rst", 8'(ball_rst), 8'd0);
      goal(1'b0, 1'b1, 1'b0);
      chk("point_goal_ignored", 8'(player2_score), 8'd0);
      ticks(PF - 1);
      chk("point_not_done", 8'(state), 8'd3);
      ticks(1);
      chk("point_to_serve", 8'(state), 8'd1);
      chk("point_to_serve_rst", 8'(ball_rst), 8'd1);
      goal(1'b1, 1'b0, 1'b0);
      chk("serve_goal_ignored", 8'(player1_score), 8'd1);
      ticks(SF);
      chk("back_to_play", 8'(state), 8'd2);

      // player 2 point with a coincident tick: counter must still run full PF
      goal(1'b0, 1'b1, 1'b1);
      chk("g2_p2", 8'(player2_score), 8'd1);
      chk("g2_serve_dir", 8'(serve_dir), 8'd0);
      chk("g2_state", 8'(state), 8'd3);
      ticks(PF - 1);
      chk("g2_tick_not_used", 8'(state), 8'd3);
      ticks(1);
      chk("g2_serve", 8'(state), 8'd1);
      ticks(SF);

      // simultaneous goals: player 1 priority
      goal(1'b1, 1'b1, 1'b0);
      chk("both_p1", 8'(player1_score), 8'd2);
      chk("both_p2", 8'(player2_score), 8'd1);
      chk("both_serve_dir", 8'(serve_dir), 8'd1);
      ticks(PF + SF);
      goal(1'b1, 1'b0, 1'b0);
      ticks(PF + SF);
      goal(1'b1, 1'b0, 1'b0);
      chk("four_p1", 8'(player1_score), 8'd4);
      ticks(PF + SF);
      chk("four_play", 8'(state), 8'd2);

      // winning point for player 1
      goal(1'b1, 1'b0, 1'b0);
      chk("win1_p1", 8'(player1_score), 8'd5);
      chk("win1_state", 8'(state), 8'd4);
      chk("win1_game_over", 8'(game_over), 8'd1);
      chk("win1_winner", 8'(winner), 8'd0);
      chk("win1_ball_rst", 8'(ball_rst), 8'd1);
      chk("win1_ball_en", 8'(ball_en), 8'd0);
      goal(1'b0, 1'b1, 1'b0);
      ticks(2);
      chk("over_goal_ignored", 8'(player2_score), 8'd1);
      chk("over_hold", 8'(state), 8'd4);

      // restart from OVER
      start_pulse();
      chk("restart_state", 8'(state), 8'd1);
      chk("restart_p1", 8'(player1_score), 8'd0);
      chk("restart_p2", 8'(player2_score), 8'd0);
      chk("restart_game_over", 8'(game_over), 8'd0);
      chk("restart_serve_dir", 8'(serve_dir), 8'd0);
      ticks(SF);

      // player 2 wins 0:5
      for (int i = 0; i < WS; i++) begin
         goal(1'b0, 1'b1, 1'b0);
         if (i < WS - 1) ticks(PF + SF);
      end
      chk("win2_p2", 8'(player2_score), 8'd5);
      chk("win2_p1", 8'(player1_score), 8'd0);
      chk("win2_state", 8'(state), 8'd4);
      chk("win2_game_over", 8'(game_over), 8'd1);
      chk("win2_winner", 8'(winner), 8'd1);

      // build 3:2, then async reset in POINT
      start_pulse();
      ticks(SF);
      goal(1'b1, 1'b0, 1'b0); ticks(PF + SF);
      goal(1'b1, 1'b0, 1'b0); ticks(PF + SF);
      goal(1'b1, 1'b0, 1'b0); ticks(PF + SF);
      goal(1'b0, 1'b1, 1'b0); ticks(PF + SF);
      goal(1'b0, 1'b1, 1'b0);
      ticks(2);
      chk("mid_p1", 8'(player1_score), 8'd3);
      chk("mid_p2", 8'(player2_score), 8'd2);
      chk("mid_state", 8'(state), 8'd3);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 8'(state), 8'd0);
      chk("arst_p1", 8'(player1_score), 8'd0);
      chk("arst_p2", 8'(player2_score), 8'd0);
      chk("arst_ball_rst", 8'(ball_rst), 8'd1);
      chk("arst_ball_en", 8'(ball_en), 8'd0);
      step();
      rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
